piso_ctrl: RTL and testbench

//   Sequencer for the 4-bit load/shift PISO path.
//   - Accepts a parallel word over a valid/ready handshake.
//   - Drives the load/shift select of an internal shift register and counts the bits out.
//   - Emits the word serially, MSB first, with framing strobes.
//   - Sits between a parallel producer (trainer switch/register bank) and a single-wire serial sink.

---
 rtl/piso_pkg.sv | 15 +
 rtl/piso_shift_reg.sv | 27 ++
 rtl/piso_ctrl.sv | 137 +++++++++++++
 tb/tb_piso_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared state encoding and counter-width helper for the PISO sequencer
package piso_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// rtl/piso_shift_reg.sv - generic load/shift register, load wins over shift, MSB on sout
module piso_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] pin,
  output logic             sout
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= pin;
    end else if (shift) begin
      q <= {q[WIDTH-2:0], 1'b0};
    end
  end

  assign sout = q[WIDTH-1];

endmodule

// File: rtl/piso_ctrl.sv
// rtl/piso_ctrl.sv - handshake-fed PISO sequencer with framing strobes and optional idle gap
// Optional trailing even-parity bit: define PISO_PARITY_EN.
module piso_ctrl
  import piso_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int IDLE_GAP = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             done,
  output logic             busy
);

  localparam int CNT_W = cnt_w(WIDTH);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [3:0]       gcnt, gcnt_nx;
  logic             accept, last, fin, msb;

  assign accept = din_valid & din_ready;

`ifdef PISO_PARITY_EN
  logic par;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par <= 1'b0;
    end else if (accept) begin
      par <= ^din;
    end
  end

  assign last = (state == ST_PAR);
`else
  assign last = (state == ST_SHIFT) && (cnt == '0);
`endif

  // Zero-gap builds accept the next word in the final frame cycle for bubble-free streaming.
  assign din_ready = !rst && ((state == ST_IDLE) || (last && (IDLE_GAP == 0)));

  piso_shift_reg #(.WIDTH(WIDTH)) u_sreg (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .shift (state == ST_SHIFT),
    .pin   (din),
    .sout  (msb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      gcnt  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      gcnt  <= gcnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    gcnt_nx  = gcnt;
    fin      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nx = ST_SHIFT;
          cnt_nx   = CNT_W'(WIDTH - 1);
        end
      end
      ST_SHIFT: begin
        if (cnt != '0) begin
          cnt_nx = cnt - 1'b1;
        end else begin
`ifdef PISO_PARITY_EN
          state_nx = ST_PAR;
`else
          fin = 1'b1;
`endif
        end
      end
      ST_PAR: begin
`ifdef PISO_PARITY_EN
        fin = 1'b1;
`else
        state_nx = ST_IDLE;
`endif
      end
      ST_GAP: begin
        if (gcnt == '0) begin
          state_nx = ST_IDLE;
        end else begin
          gcnt_nx = gcnt - 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase

    if (fin) begin
      if (IDLE_GAP > 0) begin
        state_nx = ST_GAP;
        gcnt_nx  = 4'(IDLE_GAP - 1);
      end else if (accept) begin
        state_nx = ST_SHIFT;
        cnt_nx   = CNT_W'(WIDTH - 1);
      end else begin
        state_nx = ST_IDLE;
      end
    end
  end

  always_comb begin
    sout_valid  = (state == ST_SHIFT);
    sout        = (state == ST_SHIFT) ? msb : 1'b0;
`ifdef PISO_PARITY_EN
    if (state == ST_PAR) begin
      sout_valid = 1'b1;
      sout       = par;
    end
`endif
    frame_start = (state == ST_SHIFT) && (cnt == CNT_W'(WIDTH - 1));
    done        = last;
    busy        = (state != ST_IDLE);
  end

endmodule

// File: tb/tb_piso_ctrl.sv
// tb/tb_piso_ctrl.sv - scoreboard bench for piso_ctrl (zero-gap and two-cycle-gap instances)
module tb_piso_ctrl;

`ifdef PISO_PARITY_EN
  localparam int PAR   = 1;
`else
  localparam int PAR   = 0;
`endif
  localparam int FRAME = 4 + PAR;

  typedef struct packed {
    logic b;
    logic fs;
    logic dn;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] din = '0, din2 = '0;
  logic       din_valid = 1'b0, din_valid2 = 1'b0;
  logic       din_ready, sout, sout_valid, frame_start, done, busy;
  logic       din_ready2, sout2, sout_valid2, frame_start2, done2, busy2;

  int   total = 0, bad = 0;
  int   cyc = 0, vcnt = 0, bcnt = 0, dcnt = 0, first_v = 0, last_v = 0;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  piso_ctrl #(.WIDTH(4), .IDLE_GAP(0)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .sout(sout), .sout_valid(sout_valid), .frame_start(frame_start), .done(done), .busy(busy)
  );

  piso_ctrl #(.WIDTH(4), .IDLE_GAP(2)) dut2 (
    .clk(clk), .rst(rst), .din(din2), .din_valid(din_valid2), .din_ready(din_ready2),
    .sout(sout2), .sout_valid(sout_valid2), .frame_start(frame_start2), .done(done2), .busy(busy2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (busy) bcnt++;
    if (done) dcnt++;
    if (sout_valid) begin
      if (vcnt == 0) first_v = cyc;
      last_v = cyc;
      vcnt++;
      if (q.size() == 0) begin
        check("unexpected_bit", 1, 0);
      end else begin
        e = q.pop_front();
        check("sout", sout, e.b);
        check("frame_start", frame_start, e.fs);
        check("done", done, e.dn);
        check("busy_frame", busy, 1);
      end
    end else begin
      check("sout_idle", sout, 0);
      check("fs_idle", frame_start, 0);
      check("done_idle", done, 0);
      check("busy_idle", busy, 0);
    end
  end

  task automatic push_word(input logic [3:0] w);
    for (int i = 3; i >= 0; i--)
      q.push_back('{b: w[i], fs: (i == 3), dn: (i == 0) && (PAR == 0)});
    if (PAR != 0) q.push_back('{b: ^w, fs: 1'b0, dn: 1'b1});
  endtask

  task automatic send(input logic [3:0] w);
    int n = 0;
    din       = w;
    din_valid = 1'b1;
    while (!din_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ready_timeout", 0, 1);
    push_word(w);
    @(negedge clk);
    din       = ~w;
    din_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("drain_timeout", q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int snap, n, nr, ng;
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int snap, n, nr, ng;
    repeat (3) begin
      @(negedge clk);
      check("rst_outs", {din_ready, sout, sout_valid, frame_start, done, busy}, 6'b0);
    end
    rst = 1'b0;
    #1;
    check("ready_after_rst", din_ready, 1);

    // single word, latency and framing
    @(negedge clk);
    vcnt = 0; bcnt = 0;
    send(4'b1011);
    drain();
    check("frame_len", vcnt, FRAME);
    check("busy_len", bcnt, FRAME);

    // back-to-back, no bubble
    vcnt = 0;
    send(4'hA);
    send(4'h5);
    drain();
    check("b2b_bits", vcnt, 2 * FRAME);
    check("b2b_contig", last_v - first_v, 2 * FRAME - 1);

    // two-cycle gap instance
    din2 = 4'hA; din_valid2 = 1'b1;
    n = 0;
    while (!done2 && n < 50) begin @(negedge clk); n++; end
    check("gap_done_seen", done2, 1);
    din2 = 4'h5;
    nr = 0; ng = 0; n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!frame_start2) begin
        if (!din_ready2) nr++;
        if (busy2 && !sout_valid2) ng++;
      end
    end while (!frame_start2 && n < 20);
    din_valid2 = 1'b0;
    check("gap_fs_seen", frame_start2, 1);
    check("gap_not_ready", nr, 2);
    check("gap_cycles", ng, 2);
    check("gap_msb", sout2, 0);
    repeat (12) @(negedge clk);

    // reset mid-frame
    send(4'hF);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_outs", {din_ready, sout, sout_valid, frame_start, done, busy}, 6'b0);
    q.delete();
    snap = dcnt;
    @(negedge clk);
    @(negedge clk);
    check("no_done_abandoned", dcnt, snap);
    rst = 1'b0;
    #1;
    check("ready_after_mid_rst", din_ready, 1);
    vcnt = 0;
    send(4'h3);
    drain();
    check("post_rst_frame", vcnt, FRAME);
    check("post_rst_done", dcnt, snap + 1);

    // parity patterns (parity bit scored only when enabled)
    send(4'b0111);
    drain();
    send(4'b0110);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
